multicycle_controller: RTL and testbench

Control FSM for the multicycle RV32I datapath. It replaces the single-cycle main decoder: it sequences each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles, and stalls on a memory-ready handshake. It produces every mux select and write enable for the shared ALU, register file, instruction register and unified memory, including the ALU control decode.

---
 rtl/multicycle_controller.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control FSM for a multicycle RV32I datapath. Each instruction
//               is sequenced through fetch, decode, execute, memory and
//               writeback over 3-5 cycles. The FSM stalls on a memory-ready
//               handshake and also decodes the ALU control.
// Ports       : clk, rst (async, active-high)
//               op, funct3, funct7b5 : fields from the instruction register
//               zero                 : ALU zero flag (branch resolution)
//               mem_ready            : memory completed read/write this cycle
//               PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite : enables/selects
//               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl : mux selects
//               instr_retired, illegal_op : one-cycle status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       instr_retired,
   output logic       illegal_op
);

   localparam logic [6:0] c_op_lw   = 7'b0000011;
   localparam logic [6:0] c_op_sw   = 7'b0100011;
   localparam logic [6:0] c_op_r    = 7'b0110011;
   localparam logic [6:0] c_op_i    = 7'b0010011;
   localparam logic [6:0] c_op_beq  = 7'b1100011;
   localparam logic [6:0] c_op_jal  = 7'b1101111;

   localparam logic [2:0] c_alu_add = 3'b000;
   localparam logic [2:0] c_alu_sub = 3'b001;
   localparam logic [2:0] c_alu_and = 3'b010;
   localparam logic [2:0] c_alu_or  = 3'b011;
   localparam logic [2:0] c_alu_slt = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_JAL      = 4'd8,
      S_ALUWB    = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   state_t     state_q, state_d;

   logic       pc_update, branch;
   logic [1:0] alu_op;
   logic       adr_src, mem_write, ir_write, reg_write, retired, illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Next state and Moore outputs. Outputs not set by a state stay at the
   // defaults; unused state codes fall through to default and recover.
   always_comb begin
      state_d   = S_FETCH;
      pc_update = 1'b0;
      branch    = 1'b0;
      alu_op    = 2'b00;
      adr_src   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      retired   = 1'b0;
      illegal   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_write  = mem_ready;
            pc_update = mem_ready;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            state_d   = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // PC-relative branch/jump target is precomputed here
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               c_op_lw, c_op_sw: state_d = S_MEMADR;
               c_op_r:           state_d = S_EXECUTER;
               c_op_i:           state_d = S_EXECUTEI;
               c_op_beq:         state_d = S_BEQ;
               c_op_jal:         state_d = S_JAL;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (op == c_op_lw) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_write = 1'b1;
            retired   = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            // Request held steady until the memory accepts it
            adr_src   = 1'b1;
            mem_write = 1'b1;
            retired   = mem_ready;
            state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
            state_d = S_ALUWB;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            retired   = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b01;
            branch  = 1'b1;
            retired = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Enables are masked while reset is held so that an asynchronous reset
   // aborts the instruction without any further writes.
   assign PCWrite       = ~rst & (pc_update | (branch & zero));
   assign AdrSrc        = adr_src;
   assign MemWrite      = ~rst & mem_write;
   assign IRWrite       = ~rst & ir_write;
   assign RegWrite      = ~rst & reg_write;
   assign instr_retired = ~rst & retired;
   assign illegal_op    = ~rst & illegal;

   always_comb begin
      case (op)
         c_op_sw:  ImmSrc = 2'b01;
         c_op_beq: ImmSrc = 2'b10;
         c_op_jal: ImmSrc = 2'b11;
         default:  ImmSrc = 2'b00;
      endcase
   end

   // ALU decode; op[5] separates R-type from I-ALU so addi never subtracts
   always_comb begin
      ALUControl = c_alu_add;
      case (alu_op)
         2'b01: ALUControl = c_alu_sub;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (funct7b5 & op[5]) ? c_alu_sub : c_alu_add;
               3'b010:  ALUControl = c_alu_slt;
               3'b110:  ALUControl = c_alu_or;
               3'b111:  ALUControl = c_alu_and;
               default: ALUControl = c_alu_add;
            endcase
         end
         default: ALUControl = c_alu_add;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. Each
//               instruction is expanded by a reference model into its list
//               of expected cycles (including random memory stalls), which
//               is then replayed against the DUT cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, zero, mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic       instr_retired, illegal_op;

   multicycle_controller u_dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .instr_retired(instr_retired), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010;
   localparam logic [2:0] OR_ = 3'b011, SLT = 3'b101;

   typedef struct packed {
      logic        mr;
      logic        z;
      logic [3:0]  kind;
      logic [17:0] exp;
   } rec_t;

   rec_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   ret_seen = 0;
   int   ret_exp = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t op=%b f3=%b f7=%b)",
                  tag, obs, exp, $time, op, funct3, funct7b5);
      end
   endtask

   function automatic string kname(input logic [3:0] k);
      case (k)
         4'd0: return "fetch";    4'd1: return "decode";
         4'd2: return "memadr";   4'd3: return "memread";
         4'd4: return "memwb";    4'd5: return "memwrite";
         4'd6: return "exec_r";   4'd7: return "exec_i";
         4'd8: return "jal";      4'd9: return "aluwb";
         default: return "beq";
      endcase
   endfunction

   function automatic logic [17:0] pk(input logic pcw, adr, mw, irw, rw,
                                      input logic [1:0] rs, sa, sb, imm,
                                      input logic [2:0] alu, input logic ret, ill);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ret, ill};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // ALU operation an instruction requests in its execute step
   function automatic logic [2:0] alu_model(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (o == RT && f7) ? SUB : ADD;
         3'b010:  return SLT;
         3'b110:  return OR_;
         3'b111:  return AND_;
         default: return ADD;
      endcase
   endfunction

   task automatic push(input logic [3:0] k, input logic mr, input logic z, input logic [17:0] e);
      rec_t r;
      r.mr = mr; r.z = z; r.kind = k; r.exp = e;
      q.push_back(r);
   endtask

   // Expand one instruction into the expected cycle list
   task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      logic [1:0] imm;
      logic       z;
      int         k;
      imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int i = 0; i < k; i++)
         push(4'd0, 1'b0, rb(), pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, ADD, 0, 0));
      push(4'd0, 1'b1, rb(), pk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, ADD, 0, 0));
      push(4'd1, rb(), rb(), pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, ADD, 0,
                                !(o inside {LW, SW, RT, IT, BQ, JL})));
      k = int'($urandom_range(0, 3));
      case (o)
         LW: begin
            push(4'd2, rb(), rb(), pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, ADD, 0, 0));
            for (int i = 0; i < k; i++)
               push(4'd3, 1'b0, rb(), pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, ADD, 0, 0));
            push(4'd3, 1'b1, rb(), pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, ADD, 0, 0));
            push(4'd4, rb(), rb(), pk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, ADD, 1, 0));
         end
         SW: begin
            push(4'd2, rb(), rb(), pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, ADD, 0, 0));
            for (int i = 0; i < k; i++)
               push(4'd5, 1'b0, rb(), pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, ADD, 0, 0));
            push(4'd5, 1'b1, rb(), pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, ADD, 1, 0));
         end
         RT, IT: begin
            push((o == RT) ? 4'd6 : 4'd7, rb(), rb(),
                 pk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == RT) ? 2'b00 : 2'b01, imm,
                    alu_model(o, f3, f7), 0, 0));
            push(4'd9, rb(), rb(), pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, ADD, 1, 0));
         end
         JL: begin
            push(4'd8, rb(), rb(), pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, ADD, 0, 0));
            push(4'd9, rb(), rb(), pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, ADD, 1, 0));
         end
         BQ: begin
            z = rb();
            push(4'd10, rb(), z, pk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, SUB, 1, 0));
         end
         default: ;
      endcase
      if (o inside {LW, SW, RT, IT, BQ, JL}) ret_exp++;
   endtask

   // Drive one instruction and compare every cycle; starts just after a posedge
   task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      rec_t r;
      op = o; funct3 = f3; funct7b5 = f7;
      build(o, f3, f7);
      while (q.size() > 0) begin
         r = q.pop_front();
         mem_ready = r.mr;
         zero = r.z;
         @(negedge clk);
         chk(kname(r.kind),
             {14'd0, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
              ALUSrcB, ImmSrc, ALUControl, instr_retired, illegal_op},
             {14'd0, r.exp});
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) if (!rst && instr_retired) ret_seen++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [6:0] ops[10];
   initial begin
      ops = '{LW, SW, RT, IT, BQ, JL, 7'b1110011, 7'b0110111, 7'b0000000, 7'b1111111};
      rst = 1'b1; op = RT; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      #3;
      chk("rst_irwrite", IRWrite, 1'b0);
      chk("rst_pcwrite", PCWrite, 1'b0);
      chk("rst_alusrcb", ALUSrcB, 2'b10);
      chk("rst_resultsrc", ResultSrc, 2'b10);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed: ALU decode corners, beq both ways, jal, illegal
      run(RT, 3'b000, 1'b1);
      run(IT, 3'b000, 1'b1);
      run(RT, 3'b111, 1'b0);
      run(RT, 3'b110, 1'b0);
      run(IT, 3'b010, 1'b1);
      run(BQ, 3'b000, 1'b0);
      run(BQ, 3'b001, 1'b1);
      run(JL, 3'b101, 1'b1);
      run(7'b1110011, 3'b000, 1'b0);
      run(LW, 3'b010, 1'b0);
      run(SW, 3'b010, 1'b0);

      // Randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         int idx;
         idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(6, 9)) : int'($urandom_range(0, 5));
         run(ops[idx], 3'($urandom), rb());
      end

      // Asynchronous reset during a stalled store
      op = SW; mem_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      mem_ready = 1'b0;
      @(negedge clk);
      chk("mw_stall_memwrite", MemWrite, 1'b1);
      chk("mw_stall_adrsrc", AdrSrc, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_memwrite", MemWrite, 1'b0);
      chk("rst_async_retired", instr_retired, 1'b0);
      chk("rst_async_adrsrc", AdrSrc, 1'b0);
      mem_ready = 1'b1;
      #1;
      chk("rst_async_irwrite", IRWrite, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      run(LW, 3'b010, 1'b0);
      run(BQ, 3'b000, 1'b0);

      chk("retired_count", ret_seen, ret_exp);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
